// File: rtl/rv_hello_uart_pkg.sv
// Shared types and helpers for the hello-world UART receiver.
//   rx_state_e    : receiver FSM states
//   DATA_BITS     : payload bits per frame
//   clks_per_bit(): system clocks per serial bit (truncating divide)
package rv_hello_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clock_freq, input int baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/rv_hello_uart_rx_fifo.sv
// Receive buffer: synchronous FIFO with a registered head.
//   clk, rst_n : clock, async active-low reset (contents discarded)
//   push, din  : write request and byte (ignored when full without a pop)
//   pop        : consume the head (ignored when empty)
//   full       : no free entry
//   valid, data: registered head; data holds steady until popped
module rv_hello_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic             empty, do_push, do_pop;

    // Extra MSB distinguishes full from empty when the addresses match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign wr_ptr_n = wr_ptr + (AW+1)'(do_push);
    assign rd_ptr_n = rd_ptr + (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            data   <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            valid  <= (wr_ptr_n != rd_ptr_n);
            // The new head is the byte being written this cycle when it lands
            // in the slot the read pointer moves to; otherwise it is in memory.
            if (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]))
                data <= din;
            else
                data <= mem[rd_ptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/rv_hello_uart_rx.sv
// UART receiver: 8N1 deserializer feeding a small valid/ready byte FIFO.
// Optional 8E1 framing when RV_HELLO_UART_RX_PARITY_EN is defined.
//   clk, rst_n   : clock, async active-low reset
//   urx_pin      : asynchronous serial input, idle high
//   urx_valid    : FIFO head holds a byte
//   urx_data     : FIFO head byte
//   urx_ready    : consumer takes the head on valid && ready
//   busy         : a frame is being received
//   frame_err    : one-cycle pulse on a bad stop (or parity) bit
//   overflow     : sticky, a good byte was dropped on a full FIFO
//   clr_overflow : clears overflow; beats a same-cycle set
module rv_hello_uart_rx
    import rv_hello_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 1_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       urx_pin,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int             CPB      = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int             CW       = $clog2(CPB);
    localparam logic [CW-1:0]  CNT_MID  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CPB - 1);

    logic            sync1, rx_s;
    rx_state_e       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
`ifdef RV_HELLO_UART_RX_PARITY_EN
    logic            par_err;
`endif

    logic cnt_last, pop, fifo_full, can_accept, stop_ok, push;

    // Synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= urx_pin;
            rx_s  <= sync1;
        end
    end

    assign cnt_last   = (cnt == CNT_LAST);
    assign pop        = urx_valid && urx_ready;
    assign can_accept = !fifo_full || pop;

    // A stop sample that yields a deliverable byte.
    always_comb begin
        stop_ok = (state == STOP) && cnt_last && rx_s;
`ifdef RV_HELLO_UART_RX_PARITY_EN
        stop_ok = stop_ok && !par_err;
`endif
    end

    assign push = stop_ok && can_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef RV_HELLO_UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;

            if (clr_overflow)
                overflow <= 1'b0;
            else if (stop_ok && !can_accept)
                overflow <= 1'b1;

            case (state)
                // Need a full bit time of idle before trusting a falling edge.
                WAIT_IDLE: begin
                    if (!rx_s)
                        cnt <= '0;
                    else if (cnt_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else
                        cnt <= cnt + CW'(1);
                end

                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end

                // Half a bit in: confirms the start bit and re-phases the
                // counter so later samples land mid-bit.
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else
                        cnt <= cnt + CW'(1);
                end

                DATA: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1))
`ifdef RV_HELLO_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end else
                        cnt <= cnt + CW'(1);
                end

`ifdef RV_HELLO_UART_RX_PARITY_EN
                // Even parity: the parity bit equals the XOR of the data bits.
                PARITY: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        par_err <= (rx_s != ^shreg);
                        state   <= STOP;
                    end else
                        cnt <= cnt + CW'(1);
                end
`endif

                STOP: begin
                    if (cnt_last) begin
                        cnt  <= '0;
                        busy <= 1'b0;
                        if (!rx_s) begin
                            // Bad stop / break: wait for a clean idle line.
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else begin
`ifdef RV_HELLO_UART_RX_PARITY_EN
                            if (par_err)
                                frame_err <= 1'b1;
`endif
                            state <= IDLE;
                        end
                    end else
                        cnt <= cnt + CW'(1);
                end

                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

    rv_hello_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shreg),
        .pop   (pop),
        .full  (fifo_full),
        .valid (urx_valid),
        .data  (urx_data)
    );

endmodule

// File: tb/tb_rv_hello_uart_rx.sv
// Bench for rv_hello_uart_rx at 8 clocks per bit. The bench owns a byte-level
// model: frames it transmits either land in an expected queue (bounded by the
// FIFO depth), set the overflow flag, or raise a frame_err pulse; pops follow
// valid && ready. The outputs are compared against that model every cycle.
module tb_rv_hello_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef RV_HELLO_UART_RX_PARITY_EN
    localparam int PBITS = 1;
    localparam int H_LAT = 87;
`else
    localparam int PBITS = 0;
    localparam int H_LAT = 79;
`endif
    localparam int NBITS = 10 + PBITS;
    // Edge (counted from the edge after which the start bit is driven) at which
    // the receiver samples the stop bit: 2 sync flops, 1 detect, half a bit, then
    // one full bit per data/parity bit plus the stop bit itself.
    localparam int STOP_OFF = 3 + CPB / 2 + (9 + PBITS) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       urx_pin = 1'b1;
    logic       urx_ready = 1'b1;
    logic       clr_overflow = 1'b0;
    logic       urx_valid, busy, frame_err, overflow;
    logic [7:0] urx_data;

    rv_hello_uart_rx #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (125_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .urx_pin      (urx_pin),
        .urx_valid    (urx_valid),
        .urx_data     (urx_data),
        .urx_ready    (urx_ready),
        .busy         (busy),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fe_cyc = -1;
    int         rise_cyc = -1;
    int         vld_cycles = 0;
    int         fe_pulses = 0;
    bit         prev_vld = 1'b0;
    bit         ovf_m = 1'b0;
    bit         rnd_ready = 1'b0;
    logic [7:0] q[$];
    logic [7:0] rx_log[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    task automatic cmp();
        bit ev;
        ev = (q.size() > 0);
        chk("valid", 32'(urx_valid), 32'(ev));
        if (ev && urx_valid)
            chk("data", 32'(urx_data), 32'(q[0]));
        chk("frame_err", 32'(frame_err), 32'(fe_cyc == cyc));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (urx_valid) begin
            vld_cycles++;
            if (!prev_vld) rise_cyc = cyc;
        end
        if (frame_err) fe_pulses++;
        prev_vld = urx_valid;
        if (ev && urx_ready) begin
            rx_log.push_back(urx_data);
            void'(q.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp();
        @(posedge clk);
        cyc++;
        #1;
        if (rnd_ready) urx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        urx_pin = 1'b1;
        repeat (n) tick();
    endtask

    // Transmit one frame; abort_at >= 0 stops after that many bit-clocks.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                              input int abort_at);
        logic [NBITS-1:0] fr;
        fr        = '0;
        fr[8:1]   = b;
`ifdef RV_HELLO_UART_RX_PARITY_EN
        fr[9]     = (^b) ^ par_flip;
`endif
        fr[NBITS-1] = stop_bit;
        for (int i = 0; i < NBITS * CPB; i++) begin
            if (i == abort_at) return;
            urx_pin = fr[i / CPB];
            tick();
            if (i + 1 == STOP_OFF) begin
                if (!stop_bit || par_flip) fe_cyc = cyc;
                else if (q.size() < DEPTH) q.push_back(b);
                else ovf_m = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        ovf_m  = 1'b0;
        fe_cyc = -1;
    endtask

    logic [7:0] hello [6] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

    initial begin
        int s, v0, n0, f0;
        logic [7:0] b;
        bit bad, pf;

        // Reset state
        do_reset();
        tick();
        chk("rst_valid", 32'(urx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_data", 32'(urx_data), 32'd0);
        tick();
        rst_n = 1'b1;
        idle(20);

        // Single 'h'
        s = cyc; v0 = vld_cycles; n0 = rx_log.size();
        send_frame(8'h68, 1'b1, 1'b0, -1);
        idle(4);
        chk("h_latency", 32'(rise_cyc - s), 32'(H_LAT));
        chk("h_vld_cycles", 32'(vld_cycles - v0), 32'd1);
        chk("h_count", 32'(rx_log.size() - n0), 32'd1);
        if (rx_log.size() > n0) chk("h_byte", 32'(rx_log[n0]), 32'h68);

        // "hello\n" back to back
        n0 = rx_log.size();
        foreach (hello[i]) send_frame(hello[i], 1'b1, 1'b0, -1);
        idle(20);
        chk("hello_count", 32'(rx_log.size() - n0), 32'd6);
        for (int i = 0; i < 6; i++)
            if (rx_log.size() > n0 + i) chk("hello_byte", 32'(rx_log[n0 + i]), 32'(hello[i]));
        chk("hello_no_ovf", 32'(overflow), 32'd0);

        // Overflow: 5 bytes into a 4-deep FIFO with ready low
        urx_ready = 1'b0;
        n0 = rx_log.size();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        idle(4);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head_valid", 32'(urx_valid), 32'd1);
        chk("ovf_head_data", 32'(urx_data), 32'h01);
        urx_ready = 1'b1;
        idle(8);
        chk("ovf_drain_count", 32'(rx_log.size() - n0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (rx_log.size() > n0 + i) chk("ovf_drain_byte", 32'(rx_log[n0 + i]), 32'(i + 1));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        ovf_m = 1'b0;
        tick();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // 3-clock glitch on an idle line
        n0 = rx_log.size(); f0 = fe_pulses;
        urx_pin = 1'b0;
        repeat (3) tick();
        urx_pin = 1'b1;
        chk("glitch_busy", 32'(busy), 32'd1);
        repeat (8) tick();
        chk("glitch_busy_clear", 32'(busy), 32'd0);
        idle(10);
        chk("glitch_no_byte", 32'(rx_log.size() - n0), 32'd0);
        chk("glitch_no_fe", 32'(fe_pulses - f0), 32'd0);

        // Bad stop bit, then a good frame after a clean idle
        n0 = rx_log.size(); f0 = fe_pulses;
        send_frame(8'h55, 1'b0, 1'b0, -1);
        idle(12);
        chk("stop_fe_pulses", 32'(fe_pulses - f0), 32'd1);
        chk("stop_no_byte", 32'(rx_log.size() - n0), 32'd0);
        send_frame(8'h41, 1'b1, 1'b0, -1);
        idle(4);
        chk("after_err_count", 32'(rx_log.size() - n0), 32'd1);
        if (rx_log.size() > n0) chk("after_err_byte", 32'(rx_log[n0]), 32'h41);

        // Reset in the middle of a frame, released with the line low
        n0 = rx_log.size();
        send_frame(8'hA5, 1'b1, 1'b0, 30);
        urx_pin = 1'b0;
        do_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        urx_pin = 1'b1;
        repeat (3) tick();
        urx_pin = 1'b0;
        repeat (8) tick();
        idle(20);
        chk("midrst_no_byte", 32'(rx_log.size() - n0), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(4);
        chk("midrst_next_count", 32'(rx_log.size() - n0), 32'd1);
        if (rx_log.size() > n0) chk("midrst_next_byte", 32'(rx_log[n0]), 32'h3C);

`ifdef RV_HELLO_UART_RX_PARITY_EN
        // Wrong parity
        n0 = rx_log.size(); f0 = fe_pulses;
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle(12);
        chk("par_fe_pulses", 32'(fe_pulses - f0), 32'd1);
        chk("par_no_byte", 32'(rx_log.size() - n0), 32'd0);
`endif

        // Random traffic with random back-pressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            pf  = (PBITS == 1) && ($urandom_range(0, 9) == 0);
            send_frame(b, !bad, pf, -1);
            idle(bad ? 12 : $urandom_range(0, 4));
        end
        rnd_ready = 1'b0;
        urx_ready = 1'b1;
        idle(20);
        chk("final_empty", 32'(urx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_hello_uart_rx.md
Name: rv_hello_uart_rx

Overview:
- UART 8N1 receiver and deserializer: the receiving end of the SoC's UART transmit line.
- Samples the asynchronous serial pin, validates start/stop bits and buffers received bytes in a small FIFO.
- Presents bytes on a valid/ready interface, so benches and the interactive sim top can capture program output ("hello") cycle-accurately.
- Also usable in hardware for host-to-SoC input.

Parameters:
- CLOCK_FREQ, 1_000_000, system clock in Hz.
- BAUD_RATE, 115_200, serial bit rate. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, truncated; must be >= 4.
- FIFO_DEPTH, 4, receive buffer entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- urx_pin  input  1  asynchronous serial line; idle high.
- urx_valid  output  1  FIFO head holds a byte.
- urx_data  output  8  FIFO head byte; valid only when urx_valid is high.
- urx_ready  input  1  consumer accepts the head when valid && ready.
- busy  output  1  a frame is in progress (state not IDLE/WAIT_IDLE).
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow; wins over a same-cycle set.

Behaviour:
- Input path: urx_pin passes through a 2-flop synchronizer. Both flops reset to 1. Only the synchronized value rx_s is used.
- Reset values:
  - urx_valid=0, busy=0, frame_err=0, overflow=0, urx_data=0.
  - FIFO empty; state=WAIT_IDLE.
- Bit counter: counts 0..CLKS_PER_BIT-1. Mid-bit sample point is count == CLKS_PER_BIT/2 - 1, measured from the start-bit falling edge.
- State WAIT_IDLE: requires CLKS_PER_BIT consecutive rx_s=1 cycles, then goes to IDLE. A 0 restarts the count. This prevents a reset released mid-frame from decoding a data bit as a start bit.
- State IDLE: rx_s=0 moves to START with the counter cleared.
- State START:
  - At mid-bit, rx_s=1 is a glitch: return to IDLE, no error.
  - At mid-bit, rx_s=0: counter re-phased to sample subsequent bits every CLKS_PER_BIT cycles; go to DATA with bit index 0.
- State DATA: at each sample, shift rx_s in LSB first. After bit index 7, go to STOP.
- State STOP, at the sample:
  - rx_s=1 and FIFO can accept: write the byte and go to IDLE. urx_valid rises the next cycle (sample-to-valid latency 1 clk).
  - rx_s=1 and FIFO full: drop the byte, set overflow, go to IDLE.
  - rx_s=0: drop the byte, pulse frame_err for 1 cycle, go to WAIT_IDLE. This covers break conditions.
- FIFO full / accept rule:
  - "Can accept" means not full, OR full with a pop in the same cycle. Push and pop then both happen and the count stays FIFO_DEPTH.
  - Pointers are log2(FIFO_DEPTH)+1 bits with MSB wrap; full/empty derive from pointer compare.
- FIFO pop: on urx_valid && urx_ready. Pop with empty FIFO is ignored.
- FIFO output: registered head. urx_data stays stable while urx_valid && !urx_ready.
- Reset mid-operation: all state is discarded asynchronously, including buffered bytes; the block re-enters WAIT_IDLE.

Optional Feature:
- Macro: RV_HELLO_UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1; a PARITY state is inserted between DATA and STOP.
  - The sampled parity bit must equal the XOR of the data bits.
  - On mismatch, the byte is dropped after the stop sample and frame_err pulses (same timing as a stop error). The state returns to IDLE if the stop bit is 1.
- When undefined: 8N1 only; the PARITY state and its logic are absent.

Decomposition:
- Package rv_hello_uart_pkg: state enum (WAIT_IDLE, IDLE, START, DATA, PARITY, STOP), DATA_BITS=8, and a function clks_per_bit(clock_freq, baud).
- Sub-module rv_hello_uart_rx_fifo: synchronous FIFO with push/pop, full/empty, registered head. The parent holds the FSM, synchronizer and flags.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=125_000, so CLKS_PER_BIT=8; urx_ready=1 unless stated):
- Send 0x68 ('h') after line idle -> urx_valid high for 1 cycle with urx_data=0x68, exactly 1 clk after the stop-bit mid-sample; frame_err=0.
- Send "hello\n" back-to-back -> 6 bytes received in order 68 65 6C 6C 6F 0A; no overflow.
- urx_ready=0; send 5 bytes 0x01..0x05 -> bytes 0x01..0x04 are held; 0x05 is dropped; overflow=1. Raising ready drains 01..04. clr_overflow clears overflow.
- Drive a 3-clk low glitch on an idle line -> no byte, no frame_err, busy returns to 0.
- Send 0x55 with stop bit=0 -> frame_err pulses once, no byte is written, and no reception until 8 high cycles. A following 0x41 is then received correctly.
- Assert rst_n=0 mid-DATA of 0xA5 and release with the line low -> no spurious byte; the next full frame 0x3C is received. With RV_HELLO_UART_RX_PARITY_EN defined, 0x3C with a wrong parity bit -> frame_err and no byte.
